sme_pe_scheduler: RTL and testbench

//  Sequences the string-match datapath. Waits for shared memory to report a loaded string+pattern,

---
 rtl/sme_pkg.sv | 15 +
 rtl/sme_result_merge.sv | 25 ++
 rtl/sme_pe_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_sme_pe_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine.
// Imported by the scheduler and its result merge.
package sme_pkg;

  localparam int SME_IDX_W   = 6;
  localparam int MAX_STR_LEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_REPORT
  } sched_state_t;

endpackage

// File: rtl/sme_result_merge.sv
// Lowest-numbered-hit priority select over per-PE results.
// Segments are ordered, so the lowest hit PE holds the earliest match.
module sme_result_merge
  import sme_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = SME_IDX_W
) (
  input  logic [NUM_PE-1:0]       hit,
  input  logic [NUM_PE*IDX_W-1:0] idx,
  output logic                    any,
  output logic [IDX_W-1:0]        sel
);

  always_comb begin
    any = |hit;
    sel = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel = idx[k*IDX_W +: IDX_W];
      end
    end
  end

endmodule

// File: rtl/sme_pe_scheduler.sv
// Round-based scheduler that splits candidate start positions
// across the pe_slave array and merges their results.
module sme_pe_scheduler
  import sme_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int SEG    = 8,
  parameter int IDX_W  = SME_IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  input  logic [IDX_W-1:0]        str_last_idx,
  output logic [NUM_PE-1:0]       pe_start,
  output logic [NUM_PE*IDX_W-1:0] pe_start_idx,
  output logic [NUM_PE*IDX_W-1:0] pe_end_idx,
  input  logic [NUM_PE-1:0]       pe_out_valid,
  input  logic [NUM_PE-1:0]       pe_match,
  input  logic [NUM_PE*IDX_W-1:0] pe_match_idx,
  output logic                    busy,
  output logic                    valid,
  output logic                    match,
  output logic [4:0]              match_index
);

  // One extra bit so segment bounds never wrap past last.
  localparam int W = IDX_W + 1;
  localparam logic [W-1:0] STEP   = W'(NUM_PE * SEG);
  localparam logic [W-1:0] SEG_M1 = W'(SEG - 1);

  sched_state_t state;
  sched_state_t state_nx;

  logic [W-1:0]            base;
  logic [W-1:0]            last;
  logic [NUM_PE-1:0]       done;
  logic [NUM_PE-1:0]       hit;
  logic [NUM_PE*IDX_W-1:0] hit_idx;

  logic                    accept;
  logic                    in_wait;
  logic                    all_done;
  logic                    any_hit_nx;
  logic                    more;
  logic                    adv;
  logic [NUM_PE-1:0]       take;
  logic [NUM_PE-1:0]       done_nx;
  logic [NUM_PE-1:0]       hit_nx;
  logic [NUM_PE-1:0]       go;
  logic [NUM_PE*IDX_W-1:0] s_flat;
  logic [NUM_PE*IDX_W-1:0] e_flat;
  logic                    merge_any;
  logic [IDX_W-1:0]        merge_idx;

  assign accept     = input_valid & ~busy
                    & (state == S_IDLE);
  assign in_wait    = (state == S_WAIT);
  assign take       = pe_out_valid & ~done
                    & {NUM_PE{in_wait}};
  assign done_nx    = done | take;
  assign hit_nx     = hit | (take & pe_match);
  assign all_done   = &done_nx;
  assign any_hit_nx = |hit_nx;
  assign more       = (base + STEP) <= last;
  assign adv        = in_wait & all_done
                    & ~any_hit_nx & more;

  always_comb begin : seg_calc
    logic [W-1:0] s;
    logic [W-1:0] e;
    s      = '0;
    e      = '0;
    go     = '0;
    s_flat = '0;
    e_flat = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      s = base + W'(k * SEG);
      e = s + SEG_M1;
      if (e > last) begin
        e = last;
      end
      go[k] = (s <= last);
      if (go[k]) begin
        s_flat[k*IDX_W +: IDX_W] = s[IDX_W-1:0];
        e_flat[k*IDX_W +: IDX_W] = e[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (all_done) begin
          state_nx = adv ? S_DISPATCH
                         : S_REPORT;
        end
      end
      S_REPORT: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  sme_result_merge #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_merge (
    .hit (hit),
    .idx (hit_idx),
    .any (merge_any),
    .sel (merge_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      base         <= '0;
      last         <= '0;
      done         <= '0;
      hit          <= '0;
      pe_start     <= '0;
      pe_start_idx <= '0;
      pe_end_idx   <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      match        <= 1'b0;
      match_index  <= '0;
    end else begin
      state       <= state_nx;
      pe_start    <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      if (valid) begin
        busy <= 1'b0;
      end
      if (accept) begin
        last <= {1'b0, str_last_idx};
        base <= '0;
        done <= '0;
        hit  <= '0;
        busy <= 1'b1;
      end
      if (state == S_DISPATCH) begin
        pe_start     <= go;
        pe_start_idx <= s_flat;
        pe_end_idx   <= e_flat;
        // Idle PEs count as already answered.
        done         <= ~go;
        hit          <= '0;
      end
      if (in_wait) begin
        done <= done_nx;
        hit  <= hit_nx;
        if (adv) begin
          base <= base + STEP;
          done <= '0;
          hit  <= '0;
        end
      end
      if (state == S_REPORT) begin
        valid       <= 1'b1;
        match       <= merge_any;
        match_index <= 5'(merge_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_idx <= '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (take[k]) begin
          hit_idx[k*IDX_W +: IDX_W] <=
            pe_match_idx[k*IDX_W +: IDX_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_pe_scheduler.sv
// Bench for sme_pe_scheduler: stub PEs scan a match mask,
// results are compared against a first-match reference.
module tb_sme_pe_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_iv, b_iv;
  logic [5:0]  a_last, b_last;

  logic [3:0]  a_start, a_ov, a_om;
  logic [23:0] a_sidx, a_eidx, a_oi;
  logic        a_busy, a_valid, a_match;
  logic [4:0]  a_mi;

  logic [1:0]  b_start, b_ov, b_om;
  logic [11:0] b_sidx, b_eidx, b_oi;
  logic        b_busy, b_valid, b_match;
  logic [4:0]  b_mi;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mask = '0;
  int          lat [2][4] = '{default: 1};
  int          cnt [2][4] = '{default: 0};
  logic        sv  [2][4] = '{default: 1'b0};
  logic        sm  [2][4] = '{default: 1'b0};
  logic [5:0]  si  [2][4] = '{default: 6'd0};
  logic        jv  [2][4] = '{default: 1'b0};
  logic        jm  [2][4] = '{default: 1'b0};
  logic [5:0]  ji  [2][4] = '{default: 6'd0};

  sme_pe_scheduler #(
    .NUM_PE(4), .SEG(8), .IDX_W(6)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (a_iv),
    .str_last_idx (a_last),
    .pe_start     (a_start),
    .pe_start_idx (a_sidx),
    .pe_end_idx   (a_eidx),
    .pe_out_valid (a_ov),
    .pe_match     (a_om),
    .pe_match_idx (a_oi),
    .busy         (a_busy),
    .valid        (a_valid),
    .match        (a_match),
    .match_index  (a_mi)
  );

  sme_pe_scheduler #(
    .NUM_PE(2), .SEG(4), .IDX_W(6)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (b_iv),
    .str_last_idx (b_last),
    .pe_start     (b_start),
    .pe_start_idx (b_sidx),
    .pe_end_idx   (b_eidx),
    .pe_out_valid (b_ov),
    .pe_match     (b_om),
    .pe_match_idx (b_oi),
    .busy         (b_busy),
    .valid        (b_valid),
    .match        (b_match),
    .match_index  (b_mi)
  );

  always_comb begin
    a_ov = '0; a_om = '0; a_oi = '0;
    b_ov = '0; b_om = '0; b_oi = '0;
    for (int k = 0; k < 4; k++) begin
      a_ov[k] = sv[0][k] | jv[0][k];
      a_om[k] = jv[0][k] ? jm[0][k] : sm[0][k];
      a_oi[k*6 +: 6] = jv[0][k] ? ji[0][k] : si[0][k];
    end
    for (int k = 0; k < 2; k++) begin
      b_ov[k] = sv[1][k] | jv[1][k];
      b_om[k] = jv[1][k] ? jm[1][k] : sm[1][k];
      b_oi[k*6 +: 6] = jv[1][k] ? ji[1][k] : si[1][k];
    end
  end

  function automatic int np(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int sg(int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic logic [3:0] g_startv(int d);
    if (d == 0) return a_start;
    return {2'b00, b_start};
  endfunction

  function automatic logic [3:0] g_ov(int d);
    if (d == 0) return a_ov;
    return {2'b00, b_ov};
  endfunction

  function automatic logic [5:0] g_sidx(int d, int k);
    if (d == 0) return a_sidx[k*6 +: 6];
    return b_sidx[k*6 +: 6];
  endfunction

  function automatic logic [5:0] g_eidx(int d, int k);
    if (d == 0) return a_eidx[k*6 +: 6];
    return b_eidx[k*6 +: 6];
  endfunction

  function automatic logic g_busy(int d);
    return (d == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic g_valid(int d);
    return (d == 0) ? a_valid : b_valid;
  endfunction

  function automatic logic g_match(int d);
    return (d == 0) ? a_match : b_match;
  endfunction

  function automatic logic [4:0] g_mi(int d);
    return (d == 0) ? a_mi : b_mi;
  endfunction

  // Stub PE: scan [start,end] of the mask, answer after lat cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] st;
      st = g_startv(d);
      for (int k = 0; k < np(d); k++) begin
        sv[d][k] = 1'b0;
        if (cnt[d][k] > 0) begin
          cnt[d][k]--;
          if (cnt[d][k] == 0) sv[d][k] = 1'b1;
        end
        if (st[k]) begin
          cnt[d][k] = lat[d][k];
          sm[d][k] = 1'b0;
          si[d][k] = 6'd0;
          for (int p = int'(g_eidx(d, k));
               p >= int'(g_sidx(d, k)); p--) begin
            if (mask[p]) begin
              sm[d][k] = 1'b1;
              si[d][k] = 6'(p);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_iv(input int d, input logic v,
                          input int l);
    if (d == 0) begin
      a_iv = v; a_last = 6'(l);
    end else begin
      b_iv = v; b_last = 6'(l);
    end
  endtask

  task automatic set_lat(input int d, input int l0,
                         input int l1, input int l2,
                         input int l3);
    lat[d][0] = l0; lat[d][1] = l1;
    lat[d][2] = l2; lat[d][3] = l3;
  endtask

  function automatic void ref_first(input logic [31:0] m,
                                    input int lst,
                                    output logic fm,
                                    output int fi);
    fm = 1'b0;
    fi = 0;
    for (int p = lst; p >= 0; p--) begin
      if (m[p]) begin
        fm = 1'b1;
        fi = p;
      end
    end
  endfunction

  task automatic check_dispatch(input int d, input int lst,
                                input int base,
                                input string nm);
    logic [3:0] em;
    int s, e;
    em = '0;
    for (int k = 0; k < np(d); k++) begin
      s = base + k * sg(d);
      e = (s + sg(d) - 1 > lst) ? lst : s + sg(d) - 1;
      em[k] = (s <= lst);
      chk($sformatf("%s b%0d pe%0d start_idx", nm, base, k),
          32'(g_sidx(d, k)), em[k] ? s : 0);
      chk($sformatf("%s b%0d pe%0d end_idx", nm, base, k),
          32'(g_eidx(d, k)), em[k] ? e : 0);
    end
    chk($sformatf("%s b%0d pe_start", nm, base),
        32'(g_startv(d)), 32'(em));
  endtask

  task automatic run(input string nm, input int d,
                     input int lst, input logic [31:0] m,
                     input logic [3:0] es, input logic em,
                     input int ei, input int rp_cyc,
                     input int rp_last, input int dup_cyc,
                     input int dup_pe);
    int step, rounds, lastresp, vcyc, extra, exp_rounds;
    bit got;
    step = np(d) * sg(d);
    exp_rounds = em ? (ei / step + 1) : (lst / step + 1);
    mask = m;
    drive_iv(d, 1'b1, lst);
    @(posedge clk); #1;
    drive_iv(d, 1'b0, lst);
    chk({nm, " busy after accept"}, 32'(g_busy(d)), 1);
    @(posedge clk); #1;
    chk({nm, " first pe_start"}, 32'(g_startv(d)), 32'(es));
    check_dispatch(d, lst, 0, nm);
    rounds = 1;
    lastresp = -1000;
    vcyc = 0;
    got = 1'b0;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(posedge clk); #1;
      if (g_ov(d) != 4'd0) lastresp = c;
      if (g_startv(d) != 4'd0) begin
        check_dispatch(d, lst, rounds * step, nm);
        rounds++;
      end
      if (g_valid(d)) begin
        got = 1'b1;
        vcyc = c;
      end
      if (rp_cyc == c) drive_iv(d, 1'b1, rp_last);
      else if (rp_cyc + 1 == c) drive_iv(d, 1'b0, rp_last);
      if (dup_cyc == c) begin
        jv[d][dup_pe] = 1'b1;
        jm[d][dup_pe] = 1'b1;
        ji[d][dup_pe] = 6'd2;
      end else if (dup_cyc + 1 == c) begin
        jv[d][dup_pe] = 1'b0;
      end
    end
    chk({nm, " valid within budget"}, 32'(got), 1);
    if (got) begin
      chk({nm, " match"}, 32'(g_match(d)), 32'(em));
      chk({nm, " match_index"}, 32'(g_mi(d)), ei);
      chk({nm, " busy with valid"}, 32'(g_busy(d)), 1);
      chk({nm, " resp-to-valid"}, vcyc - lastresp, 1);
      chk({nm, " rounds"}, rounds, exp_rounds);
    end
    @(posedge clk); #1;
    chk({nm, " idle outputs"},
        32'({g_valid(d), g_busy(d), g_match(d), g_mi(d)}), 0);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (g_valid(d)) extra++;
    end
    chk({nm, " extra valids"}, extra, 0);
  endtask

  typedef struct {
    int          d;
    int          last;
    logic [31:0] mask;
    int          l0, l1, l2, l3;
    logic [3:0]  es;
    logic        em;
    int          ei;
    int          rp_cyc, rp_last;
    int          dup_cyc, dup_pe;
  } vec_t;

  vec_t tv [13];

  initial begin
    int ext, lst, sel;
    logic [31:0] m;
    logic [3:0] es;
    logic fm;
    int fi;

    tv[0]  = '{0, 31, 32'h1 << 18, 3, 3, 3, 3,
               4'b1111, 1'b1, 18, 0, 0, 0, 0};
    tv[1]  = '{0, 31, (32'h1 << 9) | (32'h1 << 27), 5, 5, 5, 1,
               4'b1111, 1'b1, 9, 0, 0, 0, 0};
    tv[2]  = '{0, 5, 32'h0, 2, 2, 2, 2,
               4'b0001, 1'b0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 31, 32'h0, 1, 2, 3, 4,
               4'b1111, 1'b0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 32'h1, 1, 1, 1, 1,
               4'b0001, 1'b1, 0, 0, 0, 0, 0};
    tv[5]  = '{0, 31, 32'h8000_0000, 4, 3, 2, 1,
               4'b1111, 1'b1, 31, 0, 0, 0, 0};
    tv[6]  = '{0, 20, (32'h1 << 20) | (32'h1 << 5) | (32'h1 << 14),
               2, 2, 2, 2, 4'b0111, 1'b1, 5, 0, 0, 0, 0};
    tv[7]  = '{0, 7, 32'h1 << 8, 3, 3, 3, 3,
               4'b0001, 1'b0, 0, 0, 0, 0, 0};
    tv[8]  = '{0, 31, 32'h0, 1, 8, 8, 8,
               4'b1111, 1'b0, 0, 0, 0, 4, 0};
    tv[9]  = '{1, 20, 32'h1 << 17, 2, 2, 0, 0,
               4'b0011, 1'b1, 17, 0, 0, 0, 0};
    tv[10] = '{1, 10, 32'h1 << 15, 4, 4, 0, 0,
               4'b0011, 1'b0, 0, 2, 20, 0, 0};
    tv[11] = '{1, 31, (32'h1 << 3) | (32'h1 << 6), 3, 1, 0, 0,
               4'b0011, 1'b1, 3, 0, 0, 0, 0};
    tv[12] = '{1, 3, 32'h0, 2, 2, 0, 0,
               4'b0001, 1'b0, 0, 0, 0, 0, 0};

    reset = 1'b0;
    drive_iv(0, 1'b0, 0);
    drive_iv(1, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset a ctl",
        32'({a_busy, a_valid, a_match, a_mi, a_start}), 0);
    chk("reset a idx", 32'(|{a_sidx, a_eidx}), 0);
    chk("reset b ctl",
        32'({b_busy, b_valid, b_match, b_mi, b_start}), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      set_lat(tv[i].d, tv[i].l0, tv[i].l1, tv[i].l2, tv[i].l3);
      run($sformatf("vec%0d", i), tv[i].d, tv[i].last,
          tv[i].mask, tv[i].es, tv[i].em, tv[i].ei,
          tv[i].rp_cyc, tv[i].rp_last,
          tv[i].dup_cyc, tv[i].dup_pe);
    end

    // Abort mid-search; the stubs answer after reset release.
    set_lat(0, 10, 10, 10, 10);
    mask = 32'h1 << 3;
    drive_iv(0, 1'b1, 31);
    @(posedge clk); #1;
    drive_iv(0, 1'b0, 31);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-abort busy", 32'(a_busy), 1);
    reset = 1'b0;
    #1;
    chk("abort ctl",
        32'({a_busy, a_valid, a_match, a_mi, a_start}), 0);
    chk("abort idx", 32'(|{a_sidx, a_eidx}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    ext = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a_valid || a_busy) ext++;
    end
    chk("late pe results ignored", ext, 0);
    set_lat(0, 2, 2, 2, 2);
    run("post-abort", 0, 31, 32'h1 << 12, 4'b1111,
        1'b1, 12, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      lst = int'($urandom_range(0, 31));
      sel = int'($urandom_range(0, 3));
      if (sel == 0) m = '0;
      else if (sel == 1) m = 32'h1 << $urandom_range(0, 31);
      else m = $urandom & $urandom & $urandom;
      set_lat(d, int'($urandom_range(1, 6)),
              int'($urandom_range(1, 6)),
              int'($urandom_range(1, 6)),
              int'($urandom_range(1, 6)));
      es = '0;
      for (int k = 0; k < np(d); k++) begin
        es[k] = (k * sg(d) <= lst);
      end
      ref_first(m, lst, fm, fi);
      run($sformatf("rnd%0d", i), d, lst, m, es, fm, fi,
          0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
